// File: rtl/output_dev_pkg.sv
// Shared types and helpers for the multi-channel output device bank.
// No logic of its own; used at elaboration time only.
// No flow control.
package output_dev_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } scan_state_e;

  // Address width for n channels, never narrower than one bit so a
  // single-channel bank still has a legal address port.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_dirty_picker.sv
// Round-robin first-set finder: lowest request at or after start, with wrap.
// Purely combinational, zero cycles.
// No flow control; the caller decides when to act on the result.
module rr_dirty_picker #(
  parameter int NUM_CH = 4,
  parameter int AW     = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [AW-1:0]     start_i,
  output logic              found_o,
  output logic [AW-1:0]     idx_o
);

  int best_dist;

  // Pick the requesting channel with the smallest circular distance from start.
  always_comb begin
    found_o   = 1'b0;
    idx_o     = '0;
    best_dist = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_i[i] && (((i - int'(start_i) + NUM_CH) % NUM_CH) < best_dist)) begin
        best_dist = (i - int'(start_i) + NUM_CH) % NUM_CH;
        found_o   = 1'b1;
        idx_o     = AW'(i);
      end
    end
  end

endmodule

// File: rtl/output_device_bank.sv
// Multi-channel output register bank with change tracking and update streaming.
// Writes land at the sampling edge; a changed channel is presented one edge later.
// upd_valid holds with stable upd_ch until upd_ready; max one delivery per 2 cycles.
module output_device_bank
  import output_dev_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 32,
  localparam int AW     = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic              sel_signal,
  input  logic              restore,
  input  logic              restore_all,
  input  logic [WIDTH-1:0]  Data_in,
  output logic [WIDTH-1:0]  Data_out,
  output logic [NUM_CH-1:0] dirty,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic [AW-1:0]     upd_ch,
  output logic [WIDTH-1:0]  upd_data
);

  logic [WIDTH-1:0]  init_q [NUM_CH];
  logic [WIDTH-1:0]  init_d [NUM_CH];
  logic [WIDTH-1:0]  cur_q  [NUM_CH];
  logic [WIDTH-1:0]  cur_d  [NUM_CH];
  logic [NUM_CH-1:0] dirty_q, dirty_d;
  scan_state_e       state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     ch_q, ch_d;
  logic              found;
  logic [AW-1:0]     found_idx;
  logic              hs;

  assign upd_valid = (state_q == PRESENT);
  assign hs        = upd_valid & upd_ready;
  assign dirty     = dirty_q;
  assign upd_ch    = ch_q;

  // Readback and update-data muxes; an address with no channel reads as zero.
  always_comb begin
    Data_out = '0;
    upd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (AW'(i) == addr) Data_out = sel_signal ? cur_q[i] : init_q[i];
      if (AW'(i) == ch_q) upd_data = cur_q[i];
    end
  end

  // Command decode: restore_all beats we, which beats restore.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      init_d[i] = init_q[i];
      cur_d[i]  = cur_q[i];
      if (restore_all) begin
        cur_d[i] = init_q[i];
      end else if (we && (AW'(i) == addr)) begin
        cur_d[i] = Data_in;
        if (!sel_signal) init_d[i] = Data_in;
      end else if (restore && (AW'(i) == addr)) begin
        cur_d[i] = init_q[i];
      end
    end
  end

  // Change tracking: a real change sets the flag and outranks a delivery clear.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      dirty_d[i] = (cur_d[i] != cur_q[i]) |
                   (dirty_q[i] & ~(hs && (AW'(i) == ch_q)));
    end
  end

  rr_dirty_picker #(
    .NUM_CH (NUM_CH),
    .AW     (AW)
  ) u_picker (
    .req_i   (dirty_q),
    .start_i (ptr_q),
    .found_o (found),
    .idx_o   (found_idx)
  );

  // Scanner: IDLE picks the next dirty channel, PRESENT waits for the handshake.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ch_d    = found_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (upd_ready) begin
          state_d = IDLE;
          ptr_d   = (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        init_q[i] <= '0;
        cur_q[i]  <= '0;
      end
      dirty_q <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
    end else begin
      init_q  <= init_d;
      cur_q   <= cur_d;
      dirty_q <= dirty_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
    end
  end

endmodule
